// File: rtl/crypto_core_itf_pkg.sv
// Shared definitions for the crypto core bus interface:
//   - FSM state encoding
//   - control word bit positions {start, read, load, rst_itf, rst}
//   - status word bit positions {err_timeout, err_busy, end_op, busy}
//   - helpers that place the status and cycle-count words after the banks
package crypto_itf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } itf_state_t;

    localparam int unsigned CTRL_RST     = 0;
    localparam int unsigned CTRL_RST_ITF = 1;
    localparam int unsigned CTRL_LOAD    = 2;
    localparam int unsigned CTRL_READ    = 3;
    localparam int unsigned CTRL_START   = 4;

    localparam int unsigned STAT_BUSY        = 0;
    localparam int unsigned STAT_END_OP      = 1;
    localparam int unsigned STAT_ERR_BUSY    = 2;
    localparam int unsigned STAT_ERR_TIMEOUT = 3;
    localparam int unsigned STAT_BITS        = 4;

    function automatic int unsigned status_addr(input int unsigned in_reg,
                                                input int unsigned out_reg);
        return in_reg + out_reg;
    endfunction

    function automatic int unsigned cycles_addr(input int unsigned in_reg,
                                                input int unsigned out_reg);
        return status_addr(in_reg, out_reg) + 1;
    endfunction

endpackage

// File: rtl/crypto_core_itf_if.sv
// SoC word-bus side of the crypto core interface.
//   control  : {start, read, load, rst_itf, rst} from the bus master
//   address  : word address
//   data_in  : write data
//   data_out : registered read data (1-cycle latency)
//   end_op   : operation finished
// master modport: bus master view; slave modport: crypto_core_itf view.
interface crypto_core_itf_if #(
    parameter int unsigned WIDTH = 64
);
    logic [4:0]       control;
    logic [WIDTH-1:0] address;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             end_op;

    modport master (output control, output address, output data_in,
                    input  data_out, input  end_op);
    modport slave  (input  control, input  address, input  data_in,
                    output data_out, output end_op);
endinterface

// File: rtl/crypto_core_itf_reg_bank.sv
// itf_reg_bank: N words of WIDTH bits with async active-low reset,
// synchronous clear, single-word addressed write and full-width parallel
// capture. The flat output places word 0 in the LSBs.
//   clk, rst_n        : clock, async active-low reset
//   clr               : clear every word (highest priority)
//   wr_en/addr/data   : addressed word write
//   cap_en/cap_data   : load all words at once
//   q                 : flat bank contents
// CAPTURE selects which of capture and write wins when both are asserted.
module itf_reg_bank #(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned N       = 8,
    parameter bit          CAPTURE = 1'b0,
    localparam int unsigned AW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               cap_en,
    input  logic [N*WIDTH-1:0] cap_data,
    output logic [N*WIDTH-1:0] q
);
    logic [WIDTH-1:0] mem [N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N; i++) mem[i] <= '0;
        end else if (clr) begin
            for (int unsigned i = 0; i < N; i++) mem[i] <= '0;
        end else if (cap_en && (CAPTURE || !wr_en)) begin
            for (int unsigned i = 0; i < N; i++) mem[i] <= cap_data[i*WIDTH +: WIDTH];
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_flat
        assign q[g*WIDTH +: WIDTH] = mem[g];
    end
endmodule

// File: rtl/crypto_core_itf.sv
// crypto_core_itf: bus-to-core adapter for variable-latency crypto cores.
//   clk, i_rst : clock, async active-low reset
//   bus        : SoC word bus (control/address/data_in/data_out/end_op)
//   core_rst   : active-high core reset (soft rst or i_rst low)
//   core_start : one-cycle start pulse
//   core_in    : operand from the input bank, word 0 = LSBs
//   core_out   : core result, captured on core_valid while BUSY
//   core_valid : core result valid
// Address map: input bank, output bank, status word, cycle count, else 0.
module crypto_core_itf
    import crypto_itf_pkg::*;
#(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned IN_BITS  = 512,
    parameter int unsigned OUT_BITS = 256,
    parameter int unsigned TIMEOUT  = 2**20
) (
    input  logic                clk,
    input  logic                i_rst,
    crypto_core_itf_if.slave    bus,
    output logic                core_rst,
    output logic                core_start,
    output logic [IN_BITS-1:0]  core_in,
    input  logic [OUT_BITS-1:0] core_out,
    input  logic                core_valid
);
    localparam int unsigned IN_REG      = IN_BITS / WIDTH;
    localparam int unsigned OUT_REG     = OUT_BITS / WIDTH;
    localparam int unsigned STATUS_ADDR = status_addr(IN_REG, OUT_REG);
    localparam int unsigned CYCLES_ADDR = cycles_addr(IN_REG, OUT_REG);
    localparam int unsigned IN_AW       = (IN_REG > 1) ? $clog2(IN_REG) : 1;
    localparam int unsigned OUT_AW      = (OUT_REG > 1) ? $clog2(OUT_REG) : 1;

    logic c_rst, c_rst_itf, c_load, c_read, c_start;
    assign c_rst     = bus.control[CTRL_RST];
    assign c_rst_itf = bus.control[CTRL_RST_ITF];
    assign c_load    = bus.control[CTRL_LOAD];
    assign c_read    = bus.control[CTRL_READ];
    assign c_start   = bus.control[CTRL_START];

    itf_state_t           state, state_nxt;
    logic                 busy;
    logic                 start_ok;
    logic                 timeout_hit;
    logic [31:0]          cnt, cycles;
    logic                 err_busy, err_timeout;
    logic [STAT_BITS-1:0] status;
    logic [OUT_BITS-1:0]  out_flat;
    logic [WIDTH-1:0]     rd_word;
    logic [OUT_AW-1:0]    out_idx;

    assign core_rst    = c_rst | ~i_rst;
    assign start_ok    = c_start && (state == ST_IDLE || state == ST_DONE);
    assign timeout_hit = (TIMEOUT != 0) && (cnt == 32'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; soft reset dominates every other request
    always_comb begin
        state_nxt = state;
        if (c_rst) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (c_start) state_nxt = ST_START;
                ST_START: state_nxt = ST_BUSY;
                ST_BUSY:  if (core_valid || timeout_hit) state_nxt = ST_DONE;
                ST_DONE:  if (c_start) state_nxt = ST_START;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // Outputs decoded from state
    always_comb begin
        core_start = (state == ST_START);
        bus.end_op = (state == ST_DONE);
        busy       = (state == ST_START) || (state == ST_BUSY);
    end

    // Latency counter, captured cycle count and sticky error flags
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt         <= '0;
            cycles      <= '0;
            err_busy    <= 1'b0;
            err_timeout <= 1'b0;
        end else if (c_rst) begin
            cnt         <= '0;
            cycles      <= '0;
            err_busy    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (start_ok) begin
                cnt         <= '0;
                err_busy    <= 1'b0;
                err_timeout <= 1'b0;
            end
            if (busy && (c_load || c_start)) err_busy <= 1'b1;
            case (state)
                ST_START: cnt <= '0;
                ST_BUSY: begin
                    if (cnt != '1) cnt <= cnt + 32'd1;
                    if (core_valid)       cycles      <= cnt;
                    else if (timeout_hit) err_timeout <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    itf_reg_bank #(
        .WIDTH   (WIDTH),
        .N       (IN_REG),
        .CAPTURE (1'b0)
    ) u_in_bank (
        .clk      (clk),
        .rst_n    (i_rst),
        .clr      (c_rst_itf && !busy && !c_rst),
        .wr_en    (c_load && !busy && !c_rst && (bus.address < WIDTH'(IN_REG))),
        .wr_addr  (bus.address[IN_AW-1:0]),
        .wr_data  (bus.data_in),
        .cap_en   (1'b0),
        .cap_data ('0),
        .q        (core_in)
    );

    itf_reg_bank #(
        .WIDTH   (WIDTH),
        .N       (OUT_REG),
        .CAPTURE (1'b1)
    ) u_out_bank (
        .clk      (clk),
        .rst_n    (i_rst),
        .clr      (c_rst),
        .wr_en    (1'b0),
        .wr_addr  ('0),
        .wr_data  ('0),
        .cap_en   ((state == ST_BUSY) && core_valid && !c_rst),
        .cap_data (core_out),
        .q        (out_flat)
    );

    assign status[STAT_BUSY]        = busy;
    assign status[STAT_END_OP]      = bus.end_op;
    assign status[STAT_ERR_BUSY]    = err_busy;
    assign status[STAT_ERR_TIMEOUT] = err_timeout;

    assign out_idx = OUT_AW'(bus.address - WIDTH'(IN_REG));

    // Read address decode
    always_comb begin
        rd_word = '0;
        if (bus.address < WIDTH'(IN_REG))
            rd_word = core_in[bus.address[IN_AW-1:0]*WIDTH +: WIDTH];
        else if (bus.address < WIDTH'(STATUS_ADDR))
            rd_word = out_flat[out_idx*WIDTH +: WIDTH];
        else if (bus.address == WIDTH'(STATUS_ADDR))
            rd_word = WIDTH'(status);
        else if (bus.address == WIDTH'(CYCLES_ADDR))
            rd_word = WIDTH'(cycles);
    end

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst)                bus.data_out <= '0;
        else if (c_read && !c_rst) bus.data_out <= rd_word;
    end
endmodule

// File: tb/tb_crypto_core_itf.sv
// Directed testbench for crypto_core_itf (WIDTH=64, IN_BITS=512,
// OUT_BITS=256, TIMEOUT=16). Address map: 0..7 input, 8..11 output,
// 12 status, 13 cycle count.
module tb_crypto_core_itf;
    localparam logic [4:0] C_RST   = 5'b00001;
    localparam logic [4:0] C_ITF   = 5'b00010;
    localparam logic [4:0] C_LOAD  = 5'b00100;
    localparam logic [4:0] C_READ  = 5'b01000;
    localparam logic [4:0] C_START = 5'b10000;

    logic         clk = 1'b0;
    logic         i_rst;
    logic         core_rst, core_start, core_valid;
    logic [511:0] core_in;
    logic [255:0] core_out;

    always #5 clk = ~clk;

    crypto_core_itf_if #(.WIDTH(64)) bus ();

    crypto_core_itf #(
        .WIDTH    (64),
        .IN_BITS  (512),
        .OUT_BITS (256),
        .TIMEOUT  (16)
    ) dut (
        .clk        (clk),
        .i_rst      (i_rst),
        .bus        (bus),
        .core_rst   (core_rst),
        .core_start (core_start),
        .core_in    (core_in),
        .core_out   (core_out),
        .core_valid (core_valid)
    );

    int checks = 0;
    int errors = 0;
    logic [63:0] words [8];
    logic [63:0] res   [4];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // One bus cycle; outputs are sampled 1 time unit after the edge
    task automatic cyc(input logic [4:0] ctl, input logic [63:0] a, input logic [63:0] d);
        bus.control = ctl;
        bus.address = a;
        bus.data_in = d;
        @(posedge clk);
        #1;
        bus.control = '0;
    endtask

    task automatic rd_chk(input string tag, input logic [63:0] a, input logic [63:0] exp);
        cyc(C_READ, a, 64'd0);
        check(tag, bus.data_out, exp);
    endtask

    initial begin
        bus.control = '0;
        bus.address = '0;
        bus.data_in = '0;
        core_valid  = 1'b0;
        core_out    = '0;
        i_rst       = 1'b0;
        for (int i = 0; i < 8; i++) words[i] = 64'h1111_0000_0000_000A + 64'(i);
        res[0] = 64'h0000_0000_0000_BEEF;
        res[1] = 64'h0123_4567_89AB_CDEF;
        res[2] = 64'hFEDC_BA98_7654_3210;
        res[3] = 64'hDEAD_0000_0000_0000;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_core_rst", 64'(core_rst), 64'd1);
        check("rst_end_op", 64'(bus.end_op), 64'd0);
        check("rst_core_start", 64'(core_start), 64'd0);
        check("rst_data_out", bus.data_out, 64'd0);
        i_rst = 1'b1;
        #1;
        check("rel_core_rst", 64'(core_rst), 64'd0);
        rd_chk("rst_status", 64'd12, 64'd0);
        rd_chk("rst_in_word", 64'd5, 64'd0);

        // Load and readback
        for (int i = 0; i < 8; i++) cyc(C_LOAD, 64'(i), words[i]);
        rd_chk("rd_word3", 64'd3, words[3]);
        check("core_in_w3", core_in[255:192], words[3]);
        @(posedge clk);
        #1;
        check("data_out_hold", bus.data_out, words[3]);
        cyc(C_LOAD, 64'd14, 64'h99);
        rd_chk("oor_read", 64'd14, 64'd0);
        rd_chk("oor_status", 64'd12, 64'd0);

        // Normal run; load and start together so the core sees the new word 7
        words[7] = 64'h7777_0000_0000_0007;
        cyc(C_LOAD | C_START, 64'd7, words[7]);
        check("start_pulse", 64'(core_start), 64'd1);
        check("start_core_in_w7", core_in[511:448], words[7]);
        @(posedge clk);
        #1;
        check("start_pulse_end", 64'(core_start), 64'd0);
        repeat (10) @(posedge clk);
        #1;
        core_out   = {res[3], res[2], res[1], res[0]};
        core_valid = 1'b1;
        @(posedge clk);
        #1;
        core_valid = 1'b0;
        check("done_end_op", 64'(bus.end_op), 64'd1);
        for (int i = 0; i < 4; i++) rd_chk("result_word", 64'(8 + i), res[i]);
        rd_chk("done_status", 64'd12, 64'h2);
        rd_chk("done_cycles", 64'd13, 64'd10);

        // core_valid outside BUSY must not touch the output bank
        core_out   = ~core_out;
        core_valid = 1'b1;
        @(posedge clk);
        #1;
        core_valid = 1'b0;
        rd_chk("stray_valid", 64'd8, res[0]);
        check("stray_end_op", 64'(bus.end_op), 64'd1);

        // Busy protection
        cyc(C_START, 64'd0, 64'd0);
        check("restart_end_op", 64'(bus.end_op), 64'd0);
        @(posedge clk);
        #1;
        cyc(C_LOAD, 64'd2, 64'h55);
        rd_chk("busy_status", 64'd12, 64'h5);
        core_valid = 1'b1;
        @(posedge clk);
        #1;
        core_valid = 1'b0;
        rd_chk("busy_done_status", 64'd12, 64'h6);
        rd_chk("busy_word2", 64'd2, words[2]);
        rd_chk("busy_cycles", 64'd13, 64'd2);

        // Soft reset clears output bank, flags and cycle count
        cyc(C_RST, 64'd0, 64'd0);
        check("srst_end_op", 64'(bus.end_op), 64'd0);
        rd_chk("srst_out_bank", 64'd8, 64'd0);
        rd_chk("srst_cycles", 64'd13, 64'd0);
        rd_chk("srst_in_kept", 64'd1, words[1]);

        // Timeout: 16 BUSY cycles without core_valid
        cyc(C_START, 64'd0, 64'd0);
        repeat (16) @(posedge clk);
        #1;
        check("to_not_yet", 64'(bus.end_op), 64'd0);
        @(posedge clk);
        #1;
        check("to_end_op", 64'(bus.end_op), 64'd1);
        rd_chk("to_status", 64'd12, 64'hA);
        for (int i = 0; i < 4; i++) rd_chk("to_out_bank", 64'(8 + i), 64'd0);

        // Soft reset beats start and load in the same cycle
        cyc(C_RST | C_START | C_LOAD, 64'd0, 64'hFFFF);
        check("prio_end_op", 64'(bus.end_op), 64'd0);
        check("prio_no_start", 64'(core_start), 64'd0);
        @(posedge clk);
        #1;
        check("prio_no_start2", 64'(core_start), 64'd0);
        rd_chk("prio_word0", 64'd0, words[0]);
        rd_chk("prio_status", 64'd12, 64'd0);

        // rst_itf clears the input bank
        cyc(C_ITF, 64'd0, 64'd0);
        for (int i = 0; i < 8; i++) rd_chk("itf_clear", 64'(i), 64'd0);

        // Async reset mid-BUSY
        cyc(C_LOAD, 64'd0, 64'h42);
        rd_chk("pre_arst_word0", 64'd0, 64'h42);
        cyc(C_START, 64'd0, 64'd0);
        repeat (2) @(posedge clk);
        #2;
        i_rst = 1'b0;
        #1;
        check("arst_core_rst", 64'(core_rst), 64'd1);
        check("arst_end_op", 64'(bus.end_op), 64'd0);
        check("arst_core_start", 64'(core_start), 64'd0);
        check("arst_data_out", bus.data_out, 64'd0);
        @(posedge clk);
        #1;
        i_rst = 1'b1;
        rd_chk("arst_status", 64'd12, 64'd0);
        rd_chk("arst_word0", 64'd0, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
